// File: rtl/md_defs.sv
// rtl/md_defs.sv - MDOp encodings, latency defaults and helpers for the multiply/divide unit
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 8;

    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// rtl/md_core.sv - combinational 64-bit multiply/divide datapath producing {hi,lo}
module md_core
    import md_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        signed_div;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign signed_div = (op == MD_DIV);
    assign mag_a      = a[31] ? (~a + 32'd1) : a;
    assign mag_b      = b[31] ? (~b + 32'd1) : b;
    assign div_a      = signed_div ? mag_a : a;
    assign div_b      = signed_div ? mag_b : b;
    assign div_by_zero = (b == 32'd0);

    always_comb begin
        uq = 32'd0;
        ur = 32'd0;
        if (!div_by_zero) begin
            uq = div_a / div_b;
            ur = div_a % div_b;
        end
    end

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result[31:0]  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
                result[63:32] = a[31] ? (~ur + 32'd1) : ur;
            end
            MD_DIVU:  result = {ur, uq};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide controller owning HI/LO, busy countdown and flush
module mdu_ctrl
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ph;
    logic [31:0]      pl;
    logic             pdz;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic [63:0]      core_result;
    logic             core_dbz;

    md_core u_core (
        .a           (A),
        .b           (B),
        .op          (MDOp),
        .result      (core_result),
        .div_by_zero (core_dbz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            ph     <= 32'd0;
            pl     <= 32'd0;
            pdz    <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (Flush) begin
            // Abort wins over any request in the same cycle; HI/LO keep their committed values.
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            ph     <= 32'd0;
            pl     <= 32'd0;
            pdz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_md_arith(MDOp)) begin
                            ph     <= core_result[63:32];
                            pl     <= core_result[31:0];
                            pdz    <= is_md_div(MDOp) && core_dbz;
                            cnt    <= is_md_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end else if (MDOp == MD_MTHI) begin
                            hi_q <= A;
                        end else if (MDOp == MD_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // Requests arriving mid-run are ignored; the hazard unit stalls them upstream.
                    if (cnt <= CNT_W'(1)) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        if (!pdz) begin
                            hi_q <= ph;
                            lo_q <= pl;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
